wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 17 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/wb_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter block.
// Provides the register-address and data widths, the number of
// architectural registers tracked by the scoreboard, and the encoding
// of the writeback grant source.
package wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LSU  = 2'd2
  } grant_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that buffers ALU writeback entries.
// Ports:
//   clk_i, rst_i   - clock and synchronous active-high reset
//   push_i         - write push_data_i (ignored when full)
//   push_data_i    - entry to enqueue
//   pop_i          - drop the head entry (ignored when empty)
//   head_data_o    - current head entry
//   full_o/empty_o - occupancy flags
//   count_o        - current occupancy, 0..DEPTH
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = XLEN + REG_ADDR_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;
  logic          doPush;
  logic          doPop;

  // Guard push/pop here as well so the FIFO can never over- or underflow
  // regardless of what the caller does.
  always_comb begin
    doPush      = push_i && !full_o;
    doPop       = pop_i && !empty_o;
    full_o      = (count_q == CW'(DEPTH));
    empty_o     = (count_q == '0);
    head_data_o = mem_q[rdPtr_q];
    count_o     = count_q;
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
// ALU results are buffered in a FIFO (no backpressure, overflow is
// dropped and flagged); load results use valid/ready. Each cycle one of
// FIFO head / LSU is granted and written one cycle later. A 2-bit pending
// count per register tracks in-flight destinations announced by decode.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data    - ALU result push; alu_full = FIFO full
//   lsu_valid/lsu_rd/lsu_data    - load result; lsu_ready = LSU granted
//   iss_valid/iss_rd/iss_ready   - decode announces an in-flight rd
//   rs1/rs2, rs1_busy/rs2_busy   - hazard query
//   wen/waddr/wdata              - register-file write port
//   ovf_err                      - sticky ALU overflow flag
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DW-1:0]         alu_data,
  output logic                  alu_full,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [DW-1:0]         lsu_data,
  output logic                  lsu_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wen,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DW-1:0]         wdata,
  output logic                  ovf_err
);

  localparam int EW    = DW + REG_ADDR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  fifoPush;
  logic                  fifoPop;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [EW-1:0]         fifoHead;
  logic [CNT_W-1:0]      fifoCount;
  grant_src_e            grant;
  logic                  rrLsuPrio_q, rrLsuPrio_d;
  logic [REG_ADDR_W-1:0] selRd;
  logic [DW-1:0]         selData;
  logic                  wen_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic [DW-1:0]         wdata_q;
  logic                  ovfErr_q;
  logic [1:0]            count_q [NUM_REGS];
  logic [1:0]            count_d [NUM_REGS];
  logic                  issInc;
  logic                  wbDec;
  logic [NUM_REGS-1:0]   issHot;
  logic [NUM_REGS-1:0]   wbHot;

  assign fifoPush = alu_valid && !fifoFull && !rst;
  assign fifoPop  = (grant == GRANT_ALU);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (fifoPush),
    .push_data_i ({alu_rd, alu_data}),
    .pop_i       (fifoPop),
    .head_data_o (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .count_o     (fifoCount)
  );

  // Grant selection. A full FIFO always wins so ALU results are not lost;
  // otherwise contested cycles alternate, and only contested cycles move
  // the round-robin bit (1 = LSU has priority next contest).
  always_comb begin
    grant       = GRANT_NONE;
    rrLsuPrio_d = rrLsuPrio_q;
    if (!rst) begin
      if (!fifoEmpty && lsu_valid) begin
        if (fifoCount == CNT_W'(DEPTH)) begin
          grant = GRANT_ALU;
        end else if (rrLsuPrio_q) begin
          grant = GRANT_LSU;
        end else begin
          grant = GRANT_ALU;
        end
        rrLsuPrio_d = (grant == GRANT_ALU);
      end else if (!fifoEmpty) begin
        grant = GRANT_ALU;
      end else if (lsu_valid) begin
        grant = GRANT_LSU;
      end
    end
  end

  // Route the granted entry toward the writeback register.
  always_comb begin
    selRd   = '0;
    selData = '0;
    case (grant)
      GRANT_ALU: {selRd, selData} = fifoHead;
      GRANT_LSU: begin
        selRd   = lsu_rd;
        selData = lsu_data;
      end
      default: ;
    endcase
  end

  // Registered write port; rd=0 entries are consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= (grant != GRANT_NONE) && (selRd != '0);
      waddr_q <= selRd;
      wdata_q <= selData;
    end
  end

  // Round-robin bit and sticky overflow flag. Reset gives LSU priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrLsuPrio_q <= 1'b1;
      ovfErr_q    <= 1'b0;
    end else begin
      rrLsuPrio_q <= rrLsuPrio_d;
      if (alu_valid && fifoFull) begin
        ovfErr_q <= 1'b1;
      end
    end
  end

  // Scoreboard next state. Simultaneous issue and writeback of the same
  // register cancel out; a decrement at zero holds zero. Register 0 is
  // never pending.
  always_comb begin
    issInc = iss_valid && iss_ready && (iss_rd != '0);
    wbDec  = wen_q && (waddr_q != '0);
    issHot = issInc ? (NUM_REGS'(1) << iss_rd) : '0;
    wbHot  = wbDec ? (NUM_REGS'(1) << waddr_q) : '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = count_q[r];
      case ({issHot[r], wbHot[r]})
        2'b10: count_d[r] = count_q[r] + 2'd1;
        2'b01: if (count_q[r] != 2'd0) count_d[r] = count_q[r] - 2'd1;
        default: ;
      endcase
    end
    count_d[0] = '0;
  end

  // Scoreboard state. Decrementing on the writeback edge means busy drops
  // exactly when the register file holds the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        count_q[r] <= count_d[r];
      end
    end
  end

  // Handshake and hazard outputs are forced low while reset is applied.
  always_comb begin
    alu_full  = !rst && fifoFull;
    lsu_ready = !rst && (grant == GRANT_LSU);
    iss_ready = !rst && (count_q[iss_rd] != 2'd3);
    rs1_busy  = !rst && (rs1 != '0) && (count_q[rs1] != 2'd0);
    rs2_busy  = !rst && (rs2 != '0) && (count_q[rs2] != 2'd0);
    wen       = wen_q;
    waddr     = waddr_q;
    wdata     = wdata_q;
    ovf_err   = ovfErr_q;
  end

  // A writeback to a register with no pending count is a protocol error
  // upstream; the count saturates at zero and this flags it in simulation.
  property pWbHasPending;
    @(posedge clk) disable iff (rst) wbDec |-> (count_q[waddr_q] != 2'd0);
  endproperty
  aWbHasPending: assert property (pWbHasPending)
    else $warning("wb_arbiter: writeback to r%0d with no pending count", waddr_q);

endmodule
